// File: rtl/cpu_state_sequencer.sv
// rtl/cpu_state_sequencer.sv - one-hot instruction-cycle sequencer with fetch/load stalls, retire count and sticky timeout fault
module cpu_state_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned COUNT_WIDTH    = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  input  logic                   instrValid,
  input  logic                   load,
  input  logic                   memReadValid,
  output logic                   fetch_RequestState,
  output logic                   fetch_ReceiveState,
  output logic                   decodeState,
  output logic                   setupState,
  output logic                   executeState,
  output logic                   memReadState,
  output logic                   writebackState,
  output logic                   idle,
  output logic                   fault,
  output logic [COUNT_WIDTH-1:0] instrRetired
);

  localparam logic [3:0] S_IDLE       = 4'd0;
  localparam logic [3:0] S_FETCH_REQ  = 4'd1;
  localparam logic [3:0] S_FETCH_RECV = 4'd2;
  localparam logic [3:0] S_DECODE     = 4'd3;
  localparam logic [3:0] S_SETUP      = 4'd4;
  localparam logic [3:0] S_EXECUTE    = 4'd5;
  localparam logic [3:0] S_MEM_READ   = 4'd6;
  localparam logic [3:0] S_WRITEBACK  = 4'd7;
  localparam logic [3:0] S_FAULT      = 4'd8;

  localparam logic [15:0] LP_WAIT_LAST = 16'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic        LP_TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  logic [3:0]             r_state;
  logic [15:0]            r_wait;
  logic                   r_fetch_req;
  logic                   r_fetch_recv;
  logic                   r_decode;
  logic                   r_setup;
  logic                   r_execute;
  logic                   r_mem_read;
  logic                   r_writeback;
  logic                   r_idle;
  logic                   r_fault;
  logic [COUNT_WIDTH-1:0] r_retired;

  logic [3:0]  w_next_state;
  logic [15:0] w_next_wait;
  logic [15:0] w_wait_inc;
  logic        w_timeout;

  // Counter saturates so a disabled timeout can wait forever without wrapping.
  assign w_wait_inc = (r_wait == 16'hFFFF) ? r_wait : r_wait + 16'd1;
  assign w_timeout  = LP_TIMEOUT_EN && (r_wait == LP_WAIT_LAST);

  always_comb begin
    w_next_state = r_state;
    w_next_wait  = r_wait;
    case (r_state)
      S_IDLE: begin
        if (run) w_next_state = S_FETCH_REQ;
      end
      S_FETCH_REQ: begin
        w_next_state = S_FETCH_RECV;
        w_next_wait  = 16'd0;
      end
      S_FETCH_RECV: begin
        if (instrValid)     w_next_state = S_DECODE;
        else if (w_timeout) w_next_state = S_FAULT;
        else                w_next_wait  = w_wait_inc;
      end
      S_DECODE:  w_next_state = S_SETUP;
      S_SETUP:   w_next_state = S_EXECUTE;
      S_EXECUTE: begin
        if (load) begin
          w_next_state = S_MEM_READ;
          w_next_wait  = 16'd0;
        end else begin
          w_next_state = S_WRITEBACK;
        end
      end
      S_MEM_READ: begin
        if (memReadValid)   w_next_state = S_WRITEBACK;
        else if (w_timeout) w_next_state = S_FAULT;
        else                w_next_wait  = w_wait_inc;
      end
      S_WRITEBACK: w_next_state = run ? S_FETCH_REQ : S_IDLE;
      S_FAULT:     w_next_state = S_FAULT;
      default:     w_next_state = S_FAULT;
    endcase
  end

  // Flags are decoded from the next state so they are true registers aligned with r_state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_wait       <= 16'd0;
      r_fetch_req  <= 1'b0;
      r_fetch_recv <= 1'b0;
      r_decode     <= 1'b0;
      r_setup      <= 1'b0;
      r_execute    <= 1'b0;
      r_mem_read   <= 1'b0;
      r_writeback  <= 1'b0;
      r_idle       <= 1'b1;
      r_fault      <= 1'b0;
      r_retired    <= '0;
    end else begin
      r_state      <= w_next_state;
      r_wait       <= w_next_wait;
      r_fetch_req  <= (w_next_state == S_FETCH_REQ);
      r_fetch_recv <= (w_next_state == S_FETCH_RECV);
      r_decode     <= (w_next_state == S_DECODE);
      r_setup      <= (w_next_state == S_SETUP);
      r_execute    <= (w_next_state == S_EXECUTE);
      r_mem_read   <= (w_next_state == S_MEM_READ);
      r_writeback  <= (w_next_state == S_WRITEBACK);
      r_idle       <= (w_next_state == S_IDLE);
      r_fault      <= (w_next_state == S_FAULT);
      if (r_state == S_WRITEBACK) r_retired <= r_retired + COUNT_WIDTH'(1);
    end
  end

  assign fetch_RequestState = r_fetch_req;
  assign fetch_ReceiveState = r_fetch_recv;
  assign decodeState        = r_decode;
  assign setupState         = r_setup;
  assign executeState       = r_execute;
  assign memReadState       = r_mem_read;
  assign writebackState     = r_writeback;
  assign idle               = r_idle;
  assign fault              = r_fault;
  assign instrRetired       = r_retired;

endmodule

// File: tb/tb_cpu_state_sequencer.sv
// tb/tb_cpu_state_sequencer.sv - directed-vector bench for cpu_state_sequencer (TIMEOUT_CYCLES=8, COUNT_WIDTH=4)
module tb_cpu_state_sequencer;

  localparam logic [8:0] E_IDLE  = 9'b100000000;
  localparam logic [8:0] E_FAULT = 9'b010000000;
  localparam logic [8:0] E_REQ   = 9'b001000000;
  localparam logic [8:0] E_RECV  = 9'b000100000;
  localparam logic [8:0] E_DEC   = 9'b000010000;
  localparam logic [8:0] E_SET   = 9'b000001000;
  localparam logic [8:0] E_EXE   = 9'b000000100;
  localparam logic [8:0] E_MEM   = 9'b000000010;
  localparam logic [8:0] E_WB    = 9'b000000001;

  logic       clk = 1'b0;
  logic       reset, run, instrValid, load, memReadValid;
  logic       fetch_RequestState, fetch_ReceiveState, decodeState, setupState;
  logic       executeState, memReadState, writebackState, idle, fault;
  logic [3:0] instrRetired;

  int vecs = 0;
  int errs = 0;

  cpu_state_sequencer #(.TIMEOUT_CYCLES(8), .COUNT_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .run(run), .instrValid(instrValid), .load(load),
    .memReadValid(memReadValid),
    .fetch_RequestState(fetch_RequestState), .fetch_ReceiveState(fetch_ReceiveState),
    .decodeState(decodeState), .setupState(setupState), .executeState(executeState),
    .memReadState(memReadState), .writebackState(writebackState),
    .idle(idle), .fault(fault), .instrRetired(instrRetired)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] snap();
    return {idle, fault, fetch_RequestState, fetch_ReceiveState, decodeState,
            setupState, executeState, memReadState, writebackState};
  endfunction

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; run = 1'b0; instrValid = 1'b0; load = 1'b0; memReadValid = 1'b0;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vecs++;
    if (snap() !== E_IDLE) begin
      $display("FAIL reset_flags got=%b want=%b", snap(), E_IDLE); errs++;
    end
    vecs++;
    if (instrRetired !== 4'd0) begin
      $display("FAIL reset_count got=%0d want=0", instrRetired); errs++;
    end
    tick(2);
    vecs++;
    if (snap() !== E_IDLE) begin
      $display("FAIL idle_hold got=%b want=%b", snap(), E_IDLE); errs++;
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] seq [6];
    seq = '{E_REQ, E_RECV, E_DEC, E_SET, E_EXE, E_WB};
    do_reset();
    run = 1'b1; instrValid = 1'b1;
    tick(1);
    for (int i = 0; i < 18; i++) begin
      vecs++;
      if (snap() !== seq[i % 6]) begin
        $display("FAIL b2b_seq[%0d] got=%b want=%b", i, snap(), seq[i % 6]); errs++;
      end
      tick(1);
    end
    vecs++;
    if (instrRetired !== 4'd3) begin
      $display("FAIL b2b_count got=%0d want=3", instrRetired); errs++;
    end
    vecs++;
    if (snap() !== E_REQ) begin
      $display("FAIL b2b_no_bubble got=%b want=%b", snap(), E_REQ); errs++;
    end
  endtask

  task automatic test_load();
    logic [8:0] seq [11];
    seq = '{E_REQ, E_RECV, E_DEC, E_SET, E_EXE, E_MEM, E_MEM, E_MEM, E_MEM, E_MEM, E_WB};
    do_reset();
    run = 1'b1; instrValid = 1'b1; load = 1'b1;
    tick(1);
    run = 1'b0;
    for (int i = 0; i < 11; i++) begin
      vecs++;
      if (snap() !== seq[i]) begin
        $display("FAIL load_seq[%0d] got=%b want=%b", i, snap(), seq[i]); errs++;
      end
      memReadValid = (i == 9);
      tick(1);
    end
    memReadValid = 1'b0;
    vecs++;
    if (snap() !== E_IDLE || instrRetired !== 4'd1) begin
      $display("FAIL load_done got=%b/%0d want=%b/1", snap(), instrRetired, E_IDLE); errs++;
    end
  endtask

  task automatic test_timeout();
    do_reset();
    run = 1'b1; instrValid = 1'b1;
    tick(7);
    instrValid = 1'b0;
    vecs++;
    if (snap() !== E_REQ || instrRetired !== 4'd1) begin
      $display("FAIL to_pre got=%b/%0d want=%b/1", snap(), instrRetired, E_REQ); errs++;
    end
    tick(1);
    for (int i = 0; i < 8; i++) begin
      vecs++;
      if (snap() !== E_RECV) begin
        $display("FAIL to_wait[%0d] got=%b want=%b", i, snap(), E_RECV); errs++;
      end
      tick(1);
    end
    vecs++;
    if (snap() !== E_FAULT || instrRetired !== 4'd1) begin
      $display("FAIL to_fault got=%b/%0d want=%b/1", snap(), instrRetired, E_FAULT); errs++;
    end
    instrValid = 1'b1; memReadValid = 1'b1; load = 1'b1;
    tick(3);
    instrValid = 1'b0; memReadValid = 1'b0; load = 1'b0;
    vecs++;
    if (snap() !== E_FAULT || instrRetired !== 4'd1) begin
      $display("FAIL to_sticky got=%b/%0d want=%b/1", snap(), instrRetired, E_FAULT); errs++;
    end
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    vecs++;
    if (snap() !== E_IDLE || instrRetired !== 4'd0) begin
      $display("FAIL to_reset got=%b/%0d want=%b/0", snap(), instrRetired, E_IDLE); errs++;
    end
  endtask

  task automatic test_valid_last_cycle();
    do_reset();
    run = 1'b1;
    tick(2);
    run = 1'b0;
    for (int i = 0; i < 8; i++) begin
      vecs++;
      if (snap() !== E_RECV) begin
        $display("FAIL last_wait[%0d] got=%b want=%b", i, snap(), E_RECV); errs++;
      end
      instrValid = (i == 7);
      tick(1);
    end
    instrValid = 1'b0;
    vecs++;
    if (snap() !== E_DEC) begin
      $display("FAIL last_decode got=%b want=%b", snap(), E_DEC); errs++;
    end
    tick(4);
    vecs++;
    if (snap() !== E_IDLE || instrRetired !== 4'd1) begin
      $display("FAIL last_finish got=%b/%0d want=%b/1", snap(), instrRetired, E_IDLE); errs++;
    end
  endtask

  task automatic test_run_drop();
    logic [8:0] seq [4];
    seq = '{E_EXE, E_WB, E_IDLE, E_IDLE};
    do_reset();
    run = 1'b1; instrValid = 1'b1;
    tick(4);
    vecs++;
    if (snap() !== E_SET) begin
      $display("FAIL drop_setup got=%b want=%b", snap(), E_SET); errs++;
    end
    run = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      vecs++;
      if (snap() !== seq[i]) begin
        $display("FAIL drop_seq[%0d] got=%b want=%b", i, snap(), seq[i]); errs++;
      end
    end
    run = 1'b1;
    tick(1);
    vecs++;
    if (snap() !== E_REQ || instrRetired !== 4'd1) begin
      $display("FAIL drop_restart got=%b/%0d want=%b/1", snap(), instrRetired, E_REQ); errs++;
    end
  endtask

  task automatic test_wrap_and_reset();
    logic [3:0] exp;
    do_reset();
    run = 1'b1; instrValid = 1'b1;
    tick(1);
    for (int n = 1; n <= 17; n++) begin
      tick(6);
      exp = 4'(n % 16);
      vecs++;
      if (instrRetired !== exp || snap() !== E_REQ) begin
        $display("FAIL wrap[%0d] got=%0d/%b want=%0d/%b", n, instrRetired, snap(), exp, E_REQ); errs++;
      end
    end
    tick(4);
    vecs++;
    if (snap() !== E_EXE) begin
      $display("FAIL wrap_exec got=%b want=%b", snap(), E_EXE); errs++;
    end
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    vecs++;
    if (snap() !== E_IDLE || instrRetired !== 4'd0) begin
      $display("FAIL exec_reset got=%b/%0d want=%b/0", snap(), instrRetired, E_IDLE); errs++;
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_load();
    test_timeout();
    test_valid_last_cycle();
    test_run_drop();
    test_wrap_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
